// File: rtl/mc_accel_controller_if.sv
// mc_accel_controller_if: instruction fields, handshakes and datapath controls between controller and datapath
interface mc_accel_controller_if #(
  parameter int NUM_ACCEL = 2
);
  localparam int EW = $clog2(NUM_ACCEL + 1);
  logic [6:0] opCode;
  logic [2:0] funct3;
  logic branch;
  logic [NUM_ACCEL-1:0] accelDone;
  logic dMemReady;
  logic PCWrite;
  logic IRWrite;
  logic regFileWrite;
  logic DMemWrite;
  logic ALUOverride;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic regFileWriteSrc;
  logic [NUM_ACCEL-1:0] accelWrEna;
  logic [NUM_ACCEL-1:0] accelStart;
  logic [EW-1:0] execSrc;
  logic trap;
  logic [1:0] trapCause;
  modport master (
    input opCode, funct3, branch, accelDone, dMemReady,
    output PCWrite, IRWrite, regFileWrite, DMemWrite, ALUOverride, ALUSrcA, ALUSrcB,
    output regFileWriteSrc, accelWrEna, accelStart, execSrc, trap, trapCause
  );
  modport slave (
    output opCode, funct3, branch, accelDone, dMemReady,
    input PCWrite, IRWrite, regFileWrite, DMemWrite, ALUOverride, ALUSrcA, ALUSrcB,
    input regFileWriteSrc, accelWrEna, accelStart, execSrc, trap, trapCause
  );
endinterface

// File: rtl/mc_accel_controller.sv
// mc_accel_controller: multicycle control FSM with per-channel accelerator handshakes, timeout and trap
module mc_accel_controller #(
  parameter int NUM_ACCEL = 2,
  parameter logic [6:0] ACCEL_START_OPCODE = 7'b0001011,
  parameter logic [6:0] ACCEL_LOAD_OPCODE = 7'b0101011,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit MEM_HANDSHAKE = 1
) (
  input logic clk,
  input logic rst,
  mc_accel_controller_if.master bus
);
  localparam int EW = $clog2(NUM_ACCEL + 1);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;
  state_t state, next;
  logic [1:0] cause, cause_d;
  logic [31:0] cnt, cnt_d;
  logic [6:0] op;
  logic [NUM_ACCEL-1:0] ch_oh;
  logic legal, is_start, is_load, bad_ch, done, mem_op;
  logic pc_write, ir_write, rf_write, dm_write, alu_ovr, src_a, rf_src, trap_o;
  logic [1:0] src_b, trap_cause;
  logic [NUM_ACCEL-1:0] wr_ena, start;
  logic [EW-1:0] exec_src, ch_src;
  assign op = bus.opCode;
  assign ch_oh = NUM_ACCEL'(1) << bus.funct3;
  assign ch_src = EW'(bus.funct3) + EW'(1);
  assign is_start = op == ACCEL_START_OPCODE;
  assign is_load = op == ACCEL_LOAD_OPCODE;
  assign bad_ch = int'(bus.funct3) >= NUM_ACCEL;
  assign done = |(bus.accelDone & ch_oh);
  assign mem_op = op == OP_LOAD || op == OP_STORE;
  assign legal = op inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                            OP_LUI, OP_AUIPC, ACCEL_START_OPCODE, ACCEL_LOAD_OPCODE};
  // state, latched trap cause and accelerator wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      cause <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      cause <= cause_d;
      cnt <= cnt_d;
    end
  end
  // next-state and datapath control decode
  always_comb begin
    next = state;
    cause_d = cause;
    cnt_d = '0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    rf_write = 1'b0;
    dm_write = 1'b0;
    alu_ovr = 1'b0;
    src_a = 1'b0;
    src_b = 2'd0;
    rf_src = 1'b0;
    wr_ena = '0;
    start = '0;
    exec_src = '0;
    trap_o = 1'b0;
    trap_cause = 2'd0;
    case (state)
      FETCH: begin
        ir_write = 1'b1;
        next = DECODE;
      end
      DECODE: begin
        if (!legal) begin
          next = TRAP;
          cause_d = 2'd1;
        end else if ((is_start || is_load) && bad_ch) begin
          next = TRAP;
          cause_d = 2'd2;
        end else begin
          wr_ena = is_load ? ch_oh : '0;
          start = is_start ? ch_oh : '0;
          next = EXECUTE;
        end
      end
      EXECUTE: begin
        src_a = op inside {OP_JAL, OP_JALR, OP_AUIPC};
        src_b = (op == OP_REG || op == OP_BRANCH) ? 2'd0 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd1;
        exec_src = is_start ? ch_src : '0;
        if (!is_start || done) begin
          next = MEMORY;
        end else if (TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          next = TRAP;
          cause_d = 2'd3;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      MEMORY: begin
        alu_ovr = 1'b1;
        src_a = op != OP_JALR;
        src_b = (op == OP_JALR || op == OP_JAL) ? 2'd1 : op == OP_BRANCH ? (bus.branch ? 2'd1 : 2'd2) : 2'd2;
        dm_write = op == OP_STORE;
        exec_src = is_start ? ch_src : '0;
        next = (MEM_HANDSHAKE && mem_op && !bus.dMemReady) ? MEMORY : WRITEBACK;
      end
      WRITEBACK: begin
        pc_write = 1'b1;
        rf_write = !(op == OP_STORE || op == OP_BRANCH || is_load);
        rf_src = op == OP_LOAD;
        exec_src = is_start ? ch_src : '0;
        next = FETCH;
      end
      TRAP: begin
        trap_o = 1'b1;
        trap_cause = cause;
      end
      default: next = FETCH;
    endcase
  end
  assign bus.PCWrite = pc_write & ~rst;
  assign bus.IRWrite = ir_write & ~rst;
  assign bus.regFileWrite = rf_write & ~rst;
  assign bus.DMemWrite = dm_write & ~rst;
  assign bus.ALUOverride = alu_ovr & ~rst;
  assign bus.ALUSrcA = src_a & ~rst;
  assign bus.ALUSrcB = rst ? 2'd0 : src_b;
  assign bus.regFileWriteSrc = rf_src & ~rst;
  assign bus.accelWrEna = rst ? '0 : wr_ena;
  assign bus.accelStart = rst ? '0 : start;
  assign bus.execSrc = rst ? '0 : exec_src;
  assign bus.trap = trap_o & ~rst;
  assign bus.trapCause = rst ? 2'd0 : trap_cause;
endmodule

// File: tb/tb_mc_accel_controller.sv
// tb_mc_accel_controller: directed per-cycle checks of the multicycle accelerator controller
module tb_mc_accel_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [17:0] outs;
  mc_accel_controller_if #(.NUM_ACCEL(2)) bus();
  mc_accel_controller #(.NUM_ACCEL(2), .TIMEOUT_CYCLES(8), .MEM_HANDSHAKE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // output vector fields: PC IR RW DW AO A BB S WW SS EE T CC
  assign outs = {bus.PCWrite, bus.IRWrite, bus.regFileWrite, bus.DMemWrite, bus.ALUOverride, bus.ALUSrcA,
                 bus.ALUSrcB, bus.regFileWriteSrc, bus.accelWrEna, bus.accelStart, bus.execSrc, bus.trap, bus.trapCause};
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_START = 7'b0001011;
  localparam logic [6:0] OP_ALOAD = 7'b0101011;
  localparam logic [17:0] V_Z     = 18'b0_0_0_0_0_0_00_0_00_00_00_0_00;
  localparam logic [17:0] V_FETCH = 18'b0_1_0_0_0_0_00_0_00_00_00_0_00;
  localparam logic [17:0] V_DS0   = 18'b0_0_0_0_0_0_00_0_00_01_00_0_00;
  localparam logic [17:0] V_DS1   = 18'b0_0_0_0_0_0_00_0_00_10_00_0_00;
  localparam logic [17:0] V_DW1   = 18'b0_0_0_0_0_0_00_0_10_00_00_0_00;
  localparam logic [17:0] V_EXI   = 18'b0_0_0_0_0_0_01_0_00_00_00_0_00;
  localparam logic [17:0] V_EXA0  = 18'b0_0_0_0_0_0_01_0_00_00_01_0_00;
  localparam logic [17:0] V_EXA1  = 18'b0_0_0_0_0_0_01_0_00_00_10_0_00;
  localparam logic [17:0] V_EXJ   = 18'b0_0_0_0_0_1_10_0_00_00_00_0_00;
  localparam logic [17:0] V_MEM4  = 18'b0_0_0_0_1_1_10_0_00_00_00_0_00;
  localparam logic [17:0] V_MEMA1 = 18'b0_0_0_0_1_1_10_0_00_00_10_0_00;
  localparam logic [17:0] V_MEMB  = 18'b0_0_0_0_1_1_01_0_00_00_00_0_00;
  localparam logic [17:0] V_MEMST = 18'b0_0_0_1_1_1_10_0_00_00_00_0_00;
  localparam logic [17:0] V_WBR   = 18'b1_0_1_0_0_0_00_0_00_00_00_0_00;
  localparam logic [17:0] V_WBL   = 18'b1_0_1_0_0_0_00_1_00_00_00_0_00;
  localparam logic [17:0] V_WBA1  = 18'b1_0_1_0_0_0_00_0_00_00_10_0_00;
  localparam logic [17:0] V_WBP   = 18'b1_0_0_0_0_0_00_0_00_00_00_0_00;
  localparam logic [17:0] V_T1    = 18'b0_0_0_0_0_0_00_0_00_00_00_1_01;
  localparam logic [17:0] V_T2    = 18'b0_0_0_0_0_0_00_0_00_00_00_1_10;
  localparam logic [17:0] V_T3    = 18'b0_0_0_0_0_0_00_0_00_00_00_1_11;
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic br, input logic [1:0] dn, input logic rdy);
    bus.opCode = op;
    bus.funct3 = f3;
    bus.branch = br;
    bus.accelDone = dn;
    bus.dMemReady = rdy;
  endtask
  // reset held across a rising edge, released just after it so the next negedge sits in FETCH
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic test_reset();
    drive(OP_REG, 3'd0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs !== V_Z) begin errors++; $display("FAIL reset_outputs: got %b want %b", outs, V_Z); end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic test_alu_reg();
    logic [17:0] exp [5];
    exp = '{V_FETCH, V_Z, V_Z, V_MEM4, V_WBR};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        drive(OP_REG, 3'd0, 1'b0, 2'b00, 1'b0);
        #1;
        checks++;
        if (outs !== exp[c]) begin errors++; $display("FAIL alu_reg r%0d c%0d: got %b want %b", r, c, outs, exp[c]); end
      end
  endtask
  task automatic test_accel_start();
    logic [17:0] e;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(OP_START, 3'd1, 1'b0, c == 4 ? 2'b01 : c >= 9 ? 2'b10 : 2'b00, 1'b0);
      #1;
      e = c == 0 ? V_FETCH : c == 1 ? V_DS1 : c < 10 ? V_EXA1 : c == 10 ? V_MEMA1 : V_WBA1;
      checks++;
      if (outs !== e) begin errors++; $display("FAIL accel_start c%0d: got %b want %b", c, outs, e); end
    end
  endtask
  task automatic test_accel_load();
    logic [17:0] exp [5];
    exp = '{V_FETCH, V_DW1, V_EXI, V_MEM4, V_WBP};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(OP_ALOAD, 3'd1, 1'b0, 2'b00, 1'b0);
      #1;
      checks++;
      if (outs !== exp[c]) begin errors++; $display("FAIL accel_load c%0d: got %b want %b", c, outs, exp[c]); end
    end
  endtask
  task automatic test_timeout();
    logic [17:0] e;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      drive(c < 10 ? OP_START : OP_REG, 3'd0, 1'b0, 2'b00, 1'b0);
      #1;
      e = c == 0 ? V_FETCH : c == 1 ? V_DS0 : c < 10 ? V_EXA0 : V_T3;
      checks++;
      if (outs !== e) begin errors++; $display("FAIL timeout c%0d: got %b want %b", c, outs, e); end
    end
    do_reset();
  endtask
  task automatic test_bad_channel();
    logic [17:0] exp [4];
    exp = '{V_FETCH, V_Z, V_T2, V_T2};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(OP_START, 3'd5, 1'b0, 2'b11, 1'b1);
      #1;
      checks++;
      if (outs !== exp[c]) begin errors++; $display("FAIL bad_channel c%0d: got %b want %b", c, outs, exp[c]); end
    end
    do_reset();
  endtask
  task automatic test_illegal();
    logic [17:0] exp [4];
    exp = '{V_FETCH, V_Z, V_T1, V_T1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(7'b1111111, 3'd0, 1'b0, 2'b00, 1'b1);
      #1;
      checks++;
      if (outs !== exp[c]) begin errors++; $display("FAIL illegal c%0d: got %b want %b", c, outs, exp[c]); end
    end
    do_reset();
  endtask
  task automatic test_store_wait();
    logic [17:0] e;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(OP_STORE, 3'd0, 1'b0, 2'b00, c >= 6);
      #1;
      e = c == 0 ? V_FETCH : c == 1 ? V_Z : c == 2 ? V_EXI : c < 7 ? V_MEMST : V_WBP;
      checks++;
      if (outs !== e) begin errors++; $display("FAIL store_wait c%0d: got %b want %b", c, outs, e); end
    end
  endtask
  task automatic test_branch_jal_load();
    logic [17:0] exp [15];
    logic [6:0] ops [3];
    exp = '{V_FETCH, V_Z, V_Z, V_MEMB, V_WBP,
            V_FETCH, V_Z, V_EXJ, V_MEMB, V_WBR,
            V_FETCH, V_Z, V_EXI, V_MEM4, V_WBL};
    ops = '{OP_BRANCH, OP_JAL, OP_LOAD};
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive(ops[c / 5], 3'd0, 1'b1, 2'b00, 1'b1);
      #1;
      checks++;
      if (outs !== exp[c]) begin errors++; $display("FAIL branch_jal_load c%0d: got %b want %b", c, outs, exp[c]); end
    end
  endtask
  task automatic test_reset_mid();
    logic [17:0] e;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(OP_START, 3'd0, 1'b0, 2'b00, 1'b0);
      #1;
      e = c == 0 ? V_FETCH : c == 1 ? V_DS0 : V_EXA0;
      checks++;
      if (outs !== e) begin errors++; $display("FAIL reset_mid_pre c%0d: got %b want %b", c, outs, e); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== V_Z) begin errors++; $display("FAIL reset_mid_pulse: got %b want %b", outs, V_Z); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs !== V_FETCH) begin errors++; $display("FAIL reset_mid_fetch: got %b want %b", outs, V_FETCH); end
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      #1;
      e = c == 1 ? V_DS0 : c < 10 ? V_EXA0 : V_T3;
      checks++;
      if (outs !== e) begin errors++; $display("FAIL reset_mid_post c%0d: got %b want %b", c, outs, e); end
    end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_alu_reg();
    test_accel_start();
    test_accel_load();
    test_timeout();
    test_bad_channel();
    test_illegal();
    test_store_wait();
    test_branch_jal_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
